// File: rtl/mem_lsu.sv
// Load/store unit: turns byte/half/word core requests into whole-word RAM accesses, sub-word stores as read-modify-write.
// Optional MEM_LSU_MISALIGN_TRAP_EN: misaligned half/word requests return an error instead of being force-aligned.
module mem_lsu #(
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;
  localparam int CW = $clog2(RD_LATENCY + 2);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;

  logic [1:0]    req_off;
  logic          req_err;
  logic [31:0]   load_val;
  logic [31:0]   merge_val;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign ram_wr_en  = (state == WRITE);

  always_comb begin
    req_off = req_addr[1:0];
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    req_err = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_err = (req_size == 2'b11);
    if (req_size == 2'b01) req_off[0] = 1'b0;
    if (req_size == 2'b10) req_off = 2'b00;
`endif
  end

  // Lane extraction and merge both work straight off the RAM read port,
  // so the captured word never needs its own register.
  always_comb begin
    sel_byte = 8'(ram_data_out >> {off_q, 3'b000});
    sel_half = off_q[1] ? ram_data_out[31:16] : ram_data_out[15:0];
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & sel_byte[7]}}, sel_byte};
      2'b01:   load_val = {{16{~uns_q & sel_half[15]}}, sel_half};
      default: load_val = ram_data_out;
    endcase
    merge_val = ram_data_out;
    if (size_q == 2'b00)
      merge_val[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_val[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            size_q     <= req_size;
            off_q      <= req_off;
            wdata_q    <= req_wdata;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= req_err;
            if (req_err) begin
              state <= RESP;
            end else begin
              ram_addr <= req_addr[ADDR_WIDTH+1:2];
              if (req_we && (req_size == 2'b10)) begin
                ram_data_in <= req_wdata;
                state       <= WRITE;
              end else begin
                state <= RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          if (cnt == CW'(RD_LATENCY)) begin
            cnt <= '0;
            if (we_q) begin
              ram_data_in <= merge_val;
              state       <= WRITE;
            end else begin
              resp_rdata <= load_val;
              state      <= RESP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WRITE: state <= RESP;
        default: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: behavioural RAM with 2-cycle read latency, scoreboard of expected responses.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_wr_en;
  logic [7:0]  ram_addr;
  logic [31:0] ram_data_in, ram_data_out, rd_p1;

  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  int total = 0;
  int bad = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_wr_en) mem[ram_addr] <= ram_data_in;
    rd_p1        <= mem[ram_addr];
    ram_data_out <= rd_p1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // One request end to end: latency, write pulse position/address, response stability under backpressure.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_wr_n, input int hold);
    int n;
    int wrs;
    logic [32:0] exp;
    logic [7:0] wa;
    logic [31:0] held;
    wa = addr[9:2];
    resp_ready = (hold == 0);
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    sb_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; wrs = 0;
    chk("busy_ready", {31'd0, req_ready}, 32'd0);
    if (!exp_err) chk("ram_addr", {24'd0, ram_addr}, {24'd0, wa});
    while (!resp_valid && n < 30) begin
      if (ram_wr_en) begin
        wrs++;
        chk("wr_cycle", n, exp_wr_n);
        chk("wr_addr", {24'd0, ram_addr}, {24'd0, wa});
      end
      @(negedge clk);
      n++;
    end
    chk("resp_lat", n, exp_lat);
    chk("wr_count", wrs, (exp_wr_n != 0) ? 1 : 0);
    if (resp_valid && sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk("resp_rdata", resp_rdata, exp[31:0]);
      chk("resp_err", {31'd0, resp_err}, {31'd0, exp[32]});
    end
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, held);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    chk("post_valid", {31'd0, resp_valid}, 32'd0);
  endtask

  // Sub-word store interrupted by reset while in cycle T+at_n.
  task automatic rst_test(input int at_n, input logic [31:0] exp_word);
    int n;
    poke(8'd4, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h12; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'h000000AA;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (n < at_n) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_wr", {31'd0, ram_wr_en}, (at_n == 4) ? 32'd1 : 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wr_en", {31'd0, ram_wr_en}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_word", mem[4], exp_word);
  endtask

  initial begin
    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_wr_en", {31'd0, ram_wr_en}, 32'd0);
    chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("rst_ram_din", ram_data_in, 32'd0);
    rst = 1'b0;

    do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0);
    chk("sw_word", mem[4], 32'hDEADBEEF);
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 4, 0, 0);

    poke(8'd4, 32'h11223344);
    do_req(1'b1, 32'h12, 2'b00, 1'b0, 32'hFFFFFFAA, 32'h0, 1'b0, 5, 4, 0);
    chk("sb_word", mem[4], 32'h11AA3344);
    do_req(1'b0, 32'h12, 2'b00, 1'b0, 32'h0, 32'hFFFFFFAA, 1'b0, 4, 0, 0);
    do_req(1'b0, 32'h12, 2'b00, 1'b1, 32'h0, 32'h000000AA, 1'b0, 4, 0, 0);

    poke(8'd4, 32'h80017FFF);
    do_req(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 4, 0, 0);
    do_req(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0, 4, 0, 0);
    do_req(1'b1, 32'h10, 2'b01, 1'b0, 32'h12345555, 32'h0, 1'b0, 5, 4, 0);
    chk("sh_word", mem[4], 32'h80015555);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 32'h11, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req(1'b1, 32'h13, 2'b01, 1'b0, 32'h0000BEEF, 32'h0, 1'b1, 1, 0, 0);
`else
    do_req(1'b0, 32'h11, 2'b10, 1'b0, 32'h0, 32'h80015555, 1'b0, 4, 0, 0);
    do_req(1'b0, 32'h13, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0, 4, 0, 0);
`endif
    do_req(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req(1'b1, 32'h10, 2'b11, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0, 0);
    chk("err_no_write", mem[4], 32'h80015555);

    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h80015555, 1'b0, 4, 0, 5);
    do_req(1'b0, 32'h410, 2'b10, 1'b0, 32'h0, 32'h80015555, 1'b0, 4, 0, 0);

    rst_test(3, 32'h11223344);
    rst_test(4, 32'h11AA3344);

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
